// File: rtl/ladybird_btn_debounce_if.sv
// rtl/ladybird_btn_debounce_if.sv - button debounce signal bundle with master/slave views
interface ladybird_btn_debounce_if #(
    parameter int N_BTN = 4
);
    logic [N_BTN-1:0] btn_raw;
    logic [N_BTN-1:0] int_en;
    logic [N_BTN-1:0] int_clr;
    logic [N_BTN-1:0] btn_stable;
    logic [N_BTN-1:0] btn_rise;
    logic [N_BTN-1:0] btn_fall;
    logic [N_BTN-1:0] int_pending;
    logic             int_req;

    // Board/CPU side: drives raw levels and interrupt controls
    modport master (
        output btn_raw,
        output int_en,
        output int_clr,
        input  btn_stable,
        input  btn_rise,
        input  btn_fall,
        input  int_pending,
        input  int_req
    );

    // Debouncer side
    modport slave (
        input  btn_raw,
        input  int_en,
        input  int_clr,
        output btn_stable,
        output btn_rise,
        output btn_fall,
        output int_pending,
        output int_req
    );
endinterface

// File: rtl/ladybird_btn_debounce.sv
// rtl/ladybird_btn_debounce.sv - multi-channel button debouncer with edge pulses and sticky interrupts
module ladybird_btn_debounce #(
    parameter int          N_BTN           = 4,
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000
) (
    input  logic                  clk,
    input  logic                  rst,
    ladybird_btn_debounce_if.slave bus
);
    localparam logic [1:0] ST_STABLE_LO = 2'd0;
    localparam logic [1:0] ST_WAIT_HI   = 2'd1;
    localparam logic [1:0] ST_STABLE_HI = 2'd2;
    localparam logic [1:0] ST_WAIT_LO   = 2'd3;

    // Last count value in a WAIT state before the new level is accepted
    localparam logic [15:0] CNT_LAST = DEBOUNCE_CYCLES - 16'd1;

    logic [N_BTN-1:0] sync1_q, sync1_d;
    logic [N_BTN-1:0] sync2_q, sync2_d;
    logic [1:0]       state_q [N_BTN];
    logic [1:0]       state_d [N_BTN];
    logic [15:0]      cnt_q   [N_BTN];
    logic [15:0]      cnt_d   [N_BTN];
    logic [N_BTN-1:0] btn_stable_q, btn_stable_d;
    logic [N_BTN-1:0] btn_rise_q, btn_rise_d;
    logic [N_BTN-1:0] btn_fall_q, btn_fall_d;
    logic [N_BTN-1:0] int_pending_q, int_pending_d;

    // Next-state: synchronizer shift, per-channel debounce FSM, sticky interrupt flags
    always_comb begin
        sync1_d      = bus.btn_raw;
        sync2_d      = sync1_q;
        btn_stable_d = btn_stable_q;
        btn_rise_d   = '0;
        btn_fall_d   = '0;
        for (int i = 0; i < N_BTN; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            case (state_q[i])
                ST_STABLE_LO: begin
                    if (sync2_q[i]) begin
                        state_d[i] = ST_WAIT_HI;
                        cnt_d[i]   = 16'd1;
                    end
                end
                ST_WAIT_HI: begin
                    if (!sync2_q[i]) begin
                        // glitch: fall back without touching outputs
                        state_d[i] = ST_STABLE_LO;
                        cnt_d[i]   = 16'd0;
                    end else if (cnt_q[i] >= CNT_LAST) begin
                        state_d[i]      = ST_STABLE_HI;
                        cnt_d[i]        = 16'd0;
                        btn_stable_d[i] = 1'b1;
                        btn_rise_d[i]   = 1'b1;
                    end else begin
                        cnt_d[i] = cnt_q[i] + 16'd1;
                    end
                end
                ST_STABLE_HI: begin
                    if (!sync2_q[i]) begin
                        state_d[i] = ST_WAIT_LO;
                        cnt_d[i]   = 16'd1;
                    end
                end
                ST_WAIT_LO: begin
                    if (sync2_q[i]) begin
                        state_d[i] = ST_STABLE_HI;
                        cnt_d[i]   = 16'd0;
                    end else if (cnt_q[i] >= CNT_LAST) begin
                        state_d[i]      = ST_STABLE_LO;
                        cnt_d[i]        = 16'd0;
                        btn_stable_d[i] = 1'b0;
                        btn_fall_d[i]   = 1'b1;
                    end else begin
                        cnt_d[i] = cnt_q[i] + 16'd1;
                    end
                end
                default: begin
                    state_d[i] = ST_STABLE_LO;
                    cnt_d[i]   = 16'd0;
                end
            endcase
        end
        // set term is OR'd after the clear so a coincident rise keeps the flag
        int_pending_d = (int_pending_q & ~bus.int_clr) | (btn_rise_q & bus.int_en);
    end

    // State registers with synchronous active-high reset
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q       <= '0;
            sync2_q       <= '0;
            btn_stable_q  <= '0;
            btn_rise_q    <= '0;
            btn_fall_q    <= '0;
            int_pending_q <= '0;
            for (int i = 0; i < N_BTN; i++) begin
                state_q[i] <= ST_STABLE_LO;
                cnt_q[i]   <= 16'd0;
            end
        end else begin
            sync1_q       <= sync1_d;
            sync2_q       <= sync2_d;
            btn_stable_q  <= btn_stable_d;
            btn_rise_q    <= btn_rise_d;
            btn_fall_q    <= btn_fall_d;
            int_pending_q <= int_pending_d;
            for (int i = 0; i < N_BTN; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
        end
    end

    assign bus.btn_stable  = btn_stable_q;
    assign bus.btn_rise    = btn_rise_q;
    assign bus.btn_fall    = btn_fall_q;
    assign bus.int_pending = int_pending_q;
    assign bus.int_req     = |int_pending_q;
endmodule

// File: doc/ladybird_btn_debounce.md
LADYBIRD_BTN_DEBOUNCE -- requirements
Module: ladybird_btn_debounce

Interface
REQ-001 Parameter N_BTN, default 4: number of independent button channels, 1..8.
REQ-002 Parameter DEBOUNCE_CYCLES, default 16'd50000: consecutive cycles a new level is held before it is accepted; legal range 2..65535.
REQ-003 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1: reset, synchronous and active-high.
REQ-005 Port btn_raw, input, N_BTN: asynchronous raw board button levels, active-high.
REQ-006 Port int_en, input, N_BTN: per-channel interrupt enable.
REQ-007 Port int_clr, input, N_BTN: per-channel pending clear; one-cycle pulse or level.
REQ-008 Port btn_stable, output, N_BTN: debounced button level; the GPIO BUTTON input.
REQ-009 Port btn_rise, output, N_BTN: one-cycle pulse on each accepted 0->1 transition.
REQ-010 Port btn_fall, output, N_BTN: one-cycle pulse on each accepted 1->0 transition.
REQ-011 Port int_pending, output, N_BTN: sticky per-channel interrupt flags.
REQ-012 Port int_req, output, 1: OR of int_pending; the button interrupt toward the reset/wake logic.

Function
REQ-013 Each btn_raw bit SHALL pass through a 2-flop synchronizer (sync1, sync2) before any other use.
REQ-014 Each channel SHALL run an independent FSM with states STABLE_LO, WAIT_HI, STABLE_HI, WAIT_LO.
REQ-015 STABLE_LO with sync2=1 SHALL go to WAIT_HI with cnt=1; STABLE_HI with sync2=0 SHALL go to WAIT_LO with cnt=1.
REQ-016 In WAIT_x, when sync2 still equals the new level and cnt<DEBOUNCE_CYCLES-1, cnt SHALL increment by 1. cnt is 16 bits and never wraps.
REQ-017 In WAIT_x, when sync2 equals the new level and cnt=DEBOUNCE_CYCLES-1, the FSM SHALL enter STABLE_x on the next edge. btn_stable SHALL toggle and the matching rise/fall pulse SHALL assert in that same cycle.
REQ-018 In WAIT_x, when sync2 returns to the old level, the FSM SHALL return to the old STABLE state and clear cnt to 0, with no output change (glitch rejected).
REQ-019 Latency: if btn_raw changes before edge E and is held, btn_stable SHALL change at edge E+1+DEBOUNCE_CYCLES.
REQ-020 btn_rise and btn_fall SHALL be registered, high for exactly one cycle per accepted transition, and never high together on the same channel.
REQ-021 int_pending[i] SHALL be set on the cycle after btn_rise[i]=1 while int_en[i]=1. Falling edges SHALL never set pending.
REQ-022 int_pending[i] SHALL clear on the cycle after int_clr[i]=1. If set and clear occur in the same cycle, set SHALL win.
REQ-023 Deasserting int_en[i] SHALL NOT clear an already-set int_pending[i].
REQ-024 int_req SHALL be the combinational OR of the int_pending registers.
REQ-025 Channels SHALL NOT interact; simultaneous transitions on multiple channels SHALL be handled independently in the same cycle.

Reset
REQ-026 While rst=1 at an edge, the following SHALL be set to the given values:
- sync1, sync2, cnt: 0
- FSM: STABLE_LO
- btn_stable, btn_rise, btn_fall, int_pending: 0
REQ-027 Reset mid-debounce SHALL discard the partial count. After release, a still-high btn_raw SHALL require the full latency of REQ-019 again.
REQ-028 Outputs SHALL be defined (no X) from the first edge with rst=1; no behaviour SHALL depend on clk before the first reset.

Verification (DEBOUNCE_CYCLES=4, N_BTN=4)
REQ-029 Directed scenarios:
- btn_raw[0] 0->1 before edge 10, held -> btn_stable[0]=1 and btn_rise[0]=1 at edge 15 only; btn_rise[0]=0 at edge 16.
- btn_raw[1] high for 3 cycles then low -> btn_stable[1], btn_rise[1], int_pending[1] stay 0 throughout.
- int_en=4'b0100, stable press on channel 2 -> int_pending=4'b0100 one cycle after btn_rise[2], int_req=1. A press on channel 3 -> int_pending unchanged.
- int_clr[2]=1 in the same cycle as a new btn_rise[2] -> int_pending[2] stays 1. int_clr[2]=1 alone -> int_pending[2]=0 next cycle, int_req=0.
- rst=1 for 1 cycle while channel 0 is in WAIT_HI with cnt=2, btn_raw held high -> all outputs 0; btn_stable[0] rises 1+4 edges after rst deasserts.
- btn_raw=4'b1111 simultaneously, held, then released -> all four btn_rise pulse in the same cycle. After release, all four btn_fall pulse together and btn_stable=0.
